// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid buffer, flush, stall and perf counters
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   flush      kills every held entry, highest priority
//   stall      external hold, blocks the downstream transfer
//   in_*       upstream valid/ready/payload
//   out_*      downstream valid/ready/payload (main entry)
//   stall_cnt  saturating count of cycles with out_valid and no accept
//   bubble_cnt saturating count of cycles without out_valid
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);
   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic              rdy_q, rdy_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic              accept;
   logic              in_fire;

   assign accept = main_valid_q & out_ready & ~stall;
   // rdy_q is low through reset and then tracks ~skid_valid, so with a skid
   // buffer in_ready is a flop gated only by flush
   assign in_ready = (SKID != 0) ? rdy_q & ~flush
                                 : rdy_q & (~main_valid_q | accept) & ~flush;
   assign in_fire    = in_valid & in_ready;
   assign out_valid  = main_valid_q;
   assign out_data   = main_q;
   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_d       = '0;
         skid_d       = '0;
      end else if (accept) begin
         // in_ready is low whenever the skid entry is held, so no in_fire here
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (in_fire)
            main_d = in_data;
         else
            main_valid_d = 1'b0;
      end else if (in_fire) begin
         if (!main_valid_q) begin
            main_valid_d = 1'b1;
            main_d       = in_data;
         end else if (SKID != 0) begin
            skid_valid_d = 1'b1;
            skid_d       = in_data;
         end
      end
      rdy_d        = ~skid_valid_d;
      stall_cnt_d  = (main_valid_q & ~accept & ~(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      bubble_cnt_d = (~main_valid_q & ~(&bubble_cnt_q)) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         rdy_q        <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         rdy_q        <= rdy_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg in skid, narrow-counter and no-skid builds
module tb_pipe_stage_reg;
   logic        clk, rst, flush, stall, in_valid, out_ready;
   logic [15:0] in_data;
   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
   logic [15:0] a_out_data, b_out_data, c_out_data;
   logic [15:0] a_stall_cnt, a_bubble_cnt, c_stall_cnt, c_bubble_cnt;
   logic [1:0]  b_stall_cnt, b_bubble_cnt;
   logic [15:0] qa[$];
   logic [15:0] qc[$];
   logic [15:0] exp_sa, exp_ba, exp_sc, exp_bc;
   logic [1:0]  exp_sb, exp_bb;
   int          errors, checks, n_out_c;

   pipe_stage_reg #(.DATA_W(16), .SKID(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt));
   pipe_stage_reg #(.DATA_W(16), .SKID(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt));
   pipe_stage_reg #(.DATA_W(16), .SKID(0), .CNT_W(16)) dut_c (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
      .stall_cnt(c_stall_cnt), .bubble_cnt(c_bubble_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one clock cycle: inputs are already set, scoreboards and counter models advance, then the edge
   task automatic step();
      logic        acc_a, acc_c, fire_a, fire_c;
      logic [15:0] e;
      #1;
      acc_a  = a_out_valid && out_ready && !stall;
      acc_c  = c_out_valid && out_ready && !stall;
      fire_a = in_valid && a_in_ready;
      fire_c = in_valid && c_in_ready;
      checks++;
      if (c_in_ready !== ((!c_out_valid || acc_c) && !flush)) begin
         errors++;
         $display("FAIL c_in_ready: got %b expected %b", c_in_ready, (!c_out_valid || acc_c) && !flush);
      end
      if (flush) begin
         qa.delete();
         qc.delete();
      end else begin
         if (acc_a) begin
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL a_order: got %h expected no output", a_out_data);
            end else begin
               e = qa.pop_front();
               if (a_out_data !== e) begin
                  errors++;
                  $display("FAIL a_order: got %h expected %h", a_out_data, e);
               end
            end
         end
         if (acc_c) begin
            checks++;
            n_out_c++;
            if (qc.size() == 0) begin
               errors++;
               $display("FAIL c_order: got %h expected no output", c_out_data);
            end else begin
               e = qc.pop_front();
               if (c_out_data !== e) begin
                  errors++;
                  $display("FAIL c_order: got %h expected %h", c_out_data, e);
               end
            end
         end
         if (fire_a) qa.push_back(in_data);
         if (fire_c) qc.push_back(in_data);
      end
      if (a_out_valid && !acc_a) begin
         exp_sa = exp_sa + 16'd1;
         if (exp_sb != 2'd3) exp_sb = exp_sb + 2'd1;
      end
      if (!a_out_valid) begin
         exp_ba = exp_ba + 16'd1;
         if (exp_bb != 2'd3) exp_bb = exp_bb + 2'd1;
      end
      if (c_out_valid && !acc_c) exp_sc = exp_sc + 16'd1;
      if (!c_out_valid) exp_bc = exp_bc + 16'd1;
      @(posedge clk);
      #1;
      checks++;
      if (a_stall_cnt !== exp_sa || a_bubble_cnt !== exp_ba) begin
         errors++;
         $display("FAIL a_counters: got %0d/%0d expected %0d/%0d", a_stall_cnt, a_bubble_cnt, exp_sa, exp_ba);
      end
      checks++;
      if (b_stall_cnt !== exp_sb || b_bubble_cnt !== exp_bb) begin
         errors++;
         $display("FAIL b_counters: got %0d/%0d expected %0d/%0d", b_stall_cnt, b_bubble_cnt, exp_sb, exp_bb);
      end
      checks++;
      if (c_stall_cnt !== exp_sc || c_bubble_cnt !== exp_bc) begin
         errors++;
         $display("FAIL c_counters: got %0d/%0d expected %0d/%0d", c_stall_cnt, c_bubble_cnt, exp_sc, exp_bc);
      end
   endtask

   task automatic release_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_ba = 16'd1;
      exp_bb = 2'd1;
      exp_bc = 16'd1;
      checks++;
      if (a_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_in_ready: got %b%b expected 11", a_in_ready, c_in_ready);
      end
      checks++;
      if (a_bubble_cnt !== 16'd1 || b_bubble_cnt !== 2'd1 || a_stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL release_counters: got %0d/%0d/%0d expected 1/1/0", a_bubble_cnt, b_bubble_cnt, a_stall_cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      exp_sa = '0; exp_ba = '0; exp_sb = '0; exp_bb = '0; exp_sc = '0; exp_bc = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({a_out_valid, a_in_ready, b_in_ready, c_in_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {a_out_valid, a_in_ready, b_in_ready, c_in_ready});
      end
      checks++;
      if (a_out_data !== 16'd0 || a_stall_cnt !== 16'd0 || a_bubble_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: got %h/%0d/%0d expected 0/0/0", a_out_data, a_stall_cnt, a_bubble_cnt);
      end
      release_reset();
   endtask

   task automatic test_stream();
      logic [15:0] vals[3];
      vals = '{16'h11, 16'h22, 16'h33};
      out_ready = 1'b1;
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = vals[i];
         step();
         checks++;
         if (a_out_valid !== 1'b1 || a_out_data !== vals[i] || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_%0d: got v=%b d=%h r=%b expected v=1 d=%h r=1", i, a_out_valid, a_out_data, a_in_ready, vals[i]);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (a_out_valid !== 1'b0 || a_stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stream_drain: got v=%b stall=%0d expected v=0 stall=0", a_out_valid, a_stall_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] s0;
      s0 = exp_sa;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h000A;
      step();
      in_data = 16'h000B;
      step();
      in_data = 16'h000C;
      step();
      step();
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 16'h000A) begin
         errors++;
         $display("FAIL bp_full: got r=%b v=%b d=%h expected r=0 v=1 d=000a", a_in_ready, a_out_valid, a_out_data);
      end
      checks++;
      if (a_stall_cnt !== s0 + 16'd3) begin
         errors++;
         $display("FAIL bp_stall_cnt: got %0d expected %0d", a_stall_cnt, s0 + 16'd3);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (a_out_data !== 16'h000B || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_skid_move: got d=%h r=%b expected d=000b r=1", a_out_data, a_in_ready);
      end
      step();
      checks++;
      if (a_out_data !== 16'h000C || a_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_last: got v=%b d=%h expected v=1 d=000c", a_out_valid, a_out_data);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got %b expected 0", a_out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h0001;
      step();
      in_data = 16'h0002;
      step();
      in_data = 16'hDEAD;
      flush = 1'b1;
      step();
      checks++;
      if (a_out_valid !== 1'b0 || a_out_data !== 16'h0000) begin
         errors++;
         $display("FAIL flush_out: got v=%b d=%h expected v=0 d=0000", a_out_valid, a_out_data);
      end
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_in_ready: got %b expected 1", a_in_ready);
      end
      out_ready = 1'b1;
      repeat (2) step();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_dropped: got v=%b d=%h expected v=0", a_out_valid, a_out_data);
      end
   endtask

   task automatic test_stall();
      logic [15:0] s0;
      out_ready = 1'b1;
      stall = 1'b1;
      in_valid = 1'b1;
      in_data = 16'h0055;
      step();
      in_valid = 1'b0;
      s0 = exp_sa;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (a_out_valid !== 1'b1 || a_out_data !== 16'h0055) begin
            errors++;
            $display("FAIL stall_hold_%0d: got v=%b d=%h expected v=1 d=0055", i, a_out_valid, a_out_data);
         end
      end
      checks++;
      if (a_stall_cnt !== s0 + 16'd3) begin
         errors++;
         $display("FAIL stall_cnt: got %0d expected %0d", a_stall_cnt, s0 + 16'd3);
      end
      stall = 1'b0;
      step();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got %b expected 0", a_out_valid);
      end
   endtask

   task automatic test_saturate_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h0066;
      step();
      in_valid = 1'b0;
      repeat (6) step();
      checks++;
      if (b_stall_cnt !== 2'd3 || b_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL saturate: got cnt=%0d v=%b expected cnt=3 v=1", b_stall_cnt, b_out_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_out_data !== 16'd0 || a_in_ready !== 1'b0 || c_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_out: got v=%b d=%h r=%b%b expected 0/0000/00", a_out_valid, a_out_data, a_in_ready, c_in_ready);
      end
      checks++;
      if (a_stall_cnt !== 16'd0 || a_bubble_cnt !== 16'd0 || b_stall_cnt !== 2'd0 || b_bubble_cnt !== 2'd0) begin
         errors++;
         $display("FAIL async_reset_cnt: got %0d/%0d/%0d/%0d expected 0/0/0/0", a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt);
      end
      qa.delete();
      qc.delete();
      exp_sa = '0; exp_ba = '0; exp_sb = '0; exp_bb = '0; exp_sc = '0; exp_bc = '0;
      @(posedge clk);
      #1;
      release_reset();
   endtask

   task automatic test_random();
      n_out_c = 0;
      for (int i = 0; i < 20000 && n_out_c < 1000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         stall     = ($urandom_range(0, 3) == 0);
         step();
      end
      checks++;
      if (n_out_c < 1000) begin
         errors++;
         $display("FAIL random_timeout: got %0d items expected 1000", n_out_c);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      n_out_c = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_stall();
      test_saturate_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; successor to the fixed-field ID/EX latch.
- Carries an opaque payload bus (DATA_W bits; the integrator concatenates control and data fields) with a valid/ready handshake.
- Optional 2-entry skid buffer, so in_ready is fully registered and the ready path is cut between stages.
- Supports flush (bubble insertion), external stall, and saturating stall/bubble performance counters.
- Instantiated between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, payload width in bits (min 1).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, in_ready combinational from out_ready.
- CNT_W, 16, width of each performance counter (min 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- flush  input  1  kill all held entries; highest priority.
- stall  input  1  external hold; blocks the downstream transfer this cycle.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept the payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream can accept.
- out_data  output  DATA_W  main entry payload.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and no accept.
- bubble_cnt  output  CNT_W  cycles with out_valid=0.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; accept = out_valid & out_ready & ~stall.
- Reset (rst=0, async):
  - main_valid, skid_valid, out_data, skid data, stall_cnt and bubble_cnt all go to 0.
  - out_valid=0.
  - in_ready=0 while rst=0; 1 from the first cycle after release when SKID=1.
- Flush (priority over stall, accept and load), at the next edge:
  - main_valid=0, skid_valid=0, out_data=0, skid data=0.
  - in_ready=0 during the flush cycle; the concurrent in_valid is dropped, not transferred.
  - Counters are not cleared.
- Data moves only at an edge; latency in->out is 1 cycle when the stage is empty.
- out_data is held stable while out_valid=1 and not accepted.
- SKID=1 states (M = main valid, S = skid valid):
  - EMPTY(M0,S0): in_fire -> FULL1, main<=in_data.
  - FULL1(M1,S0):
    - in_fire & accept -> FULL1, main<=in_data.
    - in_fire & ~accept -> FULL2, skid<=in_data.
    - ~in_fire & accept -> EMPTY.
    - otherwise hold.
  - FULL2(M1,S1): accept -> FULL1, main<=skid; otherwise hold. In this state in_ready=0, so no in_fire.
  - in_ready = ~skid_valid & ~flush, a register output ANDed only with flush. S1 with M0 is unreachable.
- SKID=0:
  - in_ready = (~main_valid | accept) & ~flush. Only EMPTY and FULL1 exist.
  - in_fire loads main; accept without in_fire empties the stage.
- Order: strict FIFO, no reordering or duplication. Each accepted input is emitted exactly once unless flushed.
- stall with accept otherwise true: no transfer; counts as a stall cycle.
- Counters (start at the first edge after reset release):
  - stall_cnt +1 each cycle out_valid & ~accept.
  - bubble_cnt +1 each cycle ~out_valid.
  - Both saturate at 2^CNT_W-1; no wrap.

Test Plan:
- Reset release; stream D=0x11,0x22,0x33 with out_ready=1, stall=0, SKID=1 -> out_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first in_fire; in_ready stays 1; stall_cnt=0.
- SKID=1, hold out_ready=0 while sending 0xA,0xB,0xC -> 0xA in main, 0xB in skid, in_ready=0, 0xC held upstream. Release out_ready -> 0xA,0xB,0xC emitted in order; stall_cnt equals the held cycles.
- FULL2, assert flush with in_valid=1 (0xDEAD) -> next cycle out_valid=0, out_data=0, in_ready=1; 0xDEAD never appears at the output.
- Assert stall=1 for 3 cycles with out_ready=1, main=0x55 -> out_data stays 0x55; stall_cnt +3; 0x55 emitted on the cycle after stall drops.
- CNT_W=2, hold backpressure 6 cycles -> stall_cnt saturates at 3. Assert rst=0 mid-transfer -> outputs and counters 0 immediately, asynchronously.
- SKID=0, random valid/ready/stall traffic, 1000 items -> scoreboard shows in-order, lossless delivery; in_ready equals (~out_valid | accept) & ~flush every cycle.
